mem_sequencer: RTL

Multi-cycle sequencer that lets the single-cycle RISC-V core share one single-ported, variable-latency unified memory between instruction fetch and load/store. It sits between the core and the memory. It fetches each instruction into a holding register, runs the data access if the instruction needs one, then issues a one-cycle commit window. The core uses `~stall` as the enable for its PC flop and its register-file write. The block also counts retired instructions and halts on a bus timeout or a misaligned access.

---
 rtl/mem_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// -----------------------------------------------------------------------------
// mem_sequencer
//
// Multi-cycle sequencer that lets a single-cycle RISC-V core share one
// single-ported, variable-latency unified memory between instruction fetch
// and load/store. Each instruction is fetched into a holding register. If
// the instruction needs a data access, that access runs next. The core then
// gets a one-cycle commit window (stall=0), in which it updates its PC and
// register file.
//
// Retired instructions are counted. The sequencer halts permanently (until
// reset) on a bus timeout or a misaligned fetch/data address.
//
// Memory handshake: mem_req is the request valid and mem_ack is the
// completion. While mem_req=1, mem_we, mem_addr and mem_wdata stay stable.
// The request is held until a rising clk edge samples mem_ack=1; that edge
// completes the transfer, and mem_rdata is taken at the same edge. mem_ack
// is ignored in any cycle where mem_req=0.
//
// Parameters:
//   MAX_WAIT      cycles a request may wait for mem_ack before timeout (1..255)
//   INSTRET_INIT  reset value of the retired-instruction counter (0 normally)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   pc         in   core PC, used as the fetch address
//   memwrite   in   core decode: the held instruction is a store
//   memtoreg   in   core decode: the held instruction is a load
//   aluout     in   data address
//   writedata  in   store data
//   instr      out  held instruction to the core
//   readdata   out  held load data to the core
//   stall      out  1 = core must not update its PC or register file
//   mem_req    out  memory request, held until ack
//   mem_we     out  write strobe, valid with mem_req
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_ack
//   mem_ack    in   request complete
//   err        out  sticky error: 00 none, 01 timeout, 10 misaligned
//   instret    out  retired-instruction counter (wraps)
//   dbg_state  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_sequencer #(
    parameter int          MAX_WAIT     = 16,
    parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] instr,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  err,
    output logic [31:0] instret,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Last wait-count value that is still allowed without an ack.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] wait_cnt;
    logic [1:0] err_set;

    logic pc_misaligned;
    logic data_misaligned;
    logic is_mem;
    logic req_active;
    logic wait_expired;
    logic commit;

    assign pc_misaligned   = (pc[1:0] != 2'b00);
    assign data_misaligned = (aluout[1:0] != 2'b00);
    assign is_mem          = memwrite | memtoreg;

    // A request is live in DATA, and in FETCH only when the PC is aligned.
    // A misaligned fetch never reaches the bus.
    assign req_active   = ((state == S_FETCH) && !pc_misaligned) || (state == S_DATA);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // The core commits in EXEC for a non-memory instruction, or in WB after
    // a data access.
    assign commit = (state == S_WB) || ((state == S_EXEC) && !is_mem);

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Next-state and error-event logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        err_set    = ERR_NONE;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (pc_misaligned) begin
                    state_next = S_HALT;
                    err_set    = ERR_MISALIGN;
                end else if (mem_ack) begin
                    // An ack in the final allowed cycle wins over the timeout.
                    state_next = S_EXEC;
                end else if (wait_expired) begin
                    state_next = S_HALT;
                    err_set    = ERR_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (!is_mem) begin
                    state_next = S_FETCH;
                end else if (data_misaligned) begin
                    state_next = S_HALT;
                    err_set    = ERR_MISALIGN;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (mem_ack) begin
                    state_next = S_WB;
                end else if (wait_expired) begin
                    state_next = S_HALT;
                    err_set    = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, holding registers, error and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            instr    <= NOP_INSTR;
            readdata <= 32'h0000_0000;
            err      <= ERR_NONE;
            instret  <= INSTRET_INIT;
        end else begin
            state <= state_next;

            // Count only while waiting in the same request. Any state
            // change leaves the counter at zero, so every entry into FETCH
            // or DATA starts a fresh count.
            if (req_active && !mem_ack && (state_next == state)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end

            if ((state == S_FETCH) && req_active && mem_ack) begin
                instr <= mem_rdata;
            end

            // A store never touches readdata. Only a load captures its data.
            if ((state == S_DATA) && mem_ack && memtoreg) begin
                readdata <= mem_rdata;
            end

            // The first error wins and is kept until reset.
            if ((err == ERR_NONE) && (err_set != ERR_NONE)) begin
                err <= err_set;
            end

            if (commit) begin
                instret <= instret + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus and core-control outputs
    // ------------------------------------------------------------------
    // These are decoded from the state and the core's stable decode inputs.
    // Reset therefore forces them to their idle values immediately, and a
    // request in flight is dropped at once.
    always_comb begin
        stall     = !commit;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        case (state)
            S_FETCH: begin
                mem_req  = !pc_misaligned;
                mem_addr = pc;
            end
            S_DATA: begin
                mem_req   = 1'b1;
                mem_we    = memwrite;
                mem_addr  = aluout;
                mem_wdata = writedata;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule
